mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates the single data-memory port (2K x 16 SRAM) between the pipeline MEM stage (CPU) and a DMA/debug loader (DMA).
- Sits between the EX/MEM register outputs and the SRAM wrapper. It sequences each access through a small FSM.
- Raises a stall to the pipeline hazard logic while a CPU access is pending.
- The SRAM wrapper converts mem_wdata/mem_rdata to the bidirectional SRAM data bus.

Parameters:
- LAT, 2, SRAM access cycles per transaction (1..15).
- MAX_WAIT, 4, cycles DMA may be denied while CPU keeps requesting before DMA is forced through (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_done.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  11  word address.
- cpu_wdata  in  16  write data.
- cpu_rdata  out  16  read data, valid when cpu_done=1.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_stall  out  1  pipeline hold, combinational: cpu_req & ~cpu_done.
- dma_req  in  1  DMA request; held until dma_done.
- dma_we  in  1  1=write.
- dma_addr  in  11  word address.
- dma_wdata  in  16  write data.
- dma_rdata  out  16  read data, valid when dma_done=1.
- dma_gnt  out  1  high for the whole DMA-owned transaction.
- dma_done  out  1  one-cycle completion pulse.
- mem_en  out  1  SRAM enable.
- mem_we  out  1  SRAM write enable.
- mem_addr  out  11  SRAM address.
- mem_wdata  out  16  SRAM write data.
- mem_rdata  in  16  SRAM read data, valid on the last ACCESS cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All registered outputs go to 0: cpu_rdata, dma_rdata, cpu_done, dma_done, dma_gnt, mem_en, mem_we, mem_addr, mem_wdata.
  - wait_cnt=0, owner=CPU, access counter=0.
- Reset mid-ACCESS abandons the transaction: no done pulse, mem_en drops immediately.
- FSM states:
  - IDLE: arbitrate when cpu_req or dma_req is high. The winner's we, addr and wdata are latched into the mem_* registers, owner is recorded, and the FSM goes to ACCESS. No request: stay in IDLE.
  - ACCESS: mem_en=1 and mem_we=latched we for exactly LAT cycles; the access counter counts 0..LAT-1. On the last cycle, mem_rdata is captured into the owner's rdata register (reads only; rdata holds its old value on writes). Then go to DONE.
  - DONE: the owner's done pulses for 1 cycle, mem_en=0, then return to IDLE.
- Throughput: one transaction per LAT+2 cycles.
- Latency: a request seen in IDLE at cycle N gives done high in cycle N+LAT+1.
- Arbitration (default):
  - CPU wins unless dma_req=1 and wait_cnt==MAX_WAIT.
  - wait_cnt increments, saturating at MAX_WAIT, each IDLE cycle in which dma_req=1 and the CPU is granted.
  - wait_cnt clears when DMA is granted or dma_req=0.
- Simultaneous cpu_req and dma_req with wait_cnt<MAX_WAIT: CPU is granted; DMA waits.
- dma_gnt is 1 from the ACCESS entry edge through DONE for DMA-owned transactions.
- A requester dropping req mid-transaction does not abort it. The access completes and done still pulses.
- Inputs are sampled only at grant. Changes to addr, we or wdata during ACCESS are ignored.
- cpu_stall is the only combinational output. It is 0 in the cpu_done cycle so the pipeline advances exactly once.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined:
  - On a simultaneous request, the requester that did not own the previous transaction wins. After reset, the CPU has priority.
  - wait_cnt and MAX_WAIT are unused.
- ARB_ROUND_ROBIN_EN undefined: CPU priority with MAX_WAIT starvation guard, as in Behaviour.

Test Plan (LAT=2, MAX_WAIT=4):
- Reset: assert rst=0 mid-run -> all registered outputs 0, FSM in IDLE, cpu_stall=cpu_req.
- CPU write/read: CPU writes 0x0123 to 0x005 (cycle 0) -> mem_en=1 in cycles 1-2, cpu_done=1 in cycle 3, cpu_stall=1 in cycles 0-2. Then read 0x005 -> cpu_rdata=0x0123 when cpu_done=1.
- Simultaneous requests: CPU read 0x010 and DMA write 0xBEEF to 0x020 in the same cycle -> CPU done first. DMA is granted in the next IDLE; a following CPU read of 0x020 returns 0xBEEF.
- Starvation: CPU issues back-to-back requests and dma_req is held high -> after 4 CPU grants, DMA is granted (dma_gnt=1) while cpu_req is high; wait_cnt returns to 0.
- Reset mid-access: rst=0 in the second ACCESS cycle of a CPU write -> no cpu_done. After rst=1 the FSM is in IDLE and mem_en=0.
- ARB_ROUND_ROBIN_EN: both requests held continuously -> grants alternate CPU, DMA, CPU, DMA, each DONE spaced 4 cycles apart.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the CPU, DMA and SRAM-side signals of the
// data-memory port arbiter. The slave modport is the arbiter's view; the
// master modport is the view of the requesters and SRAM wrapper.
interface mem_port_arbiter_if;
    // CPU (pipeline MEM stage) side
    logic        cpu_req;
    logic        cpu_we;
    logic [10:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_done;
    logic        cpu_stall;
    // DMA / debug loader side
    logic        dma_req;
    logic        dma_we;
    logic [10:0] dma_addr;
    logic [15:0] dma_wdata;
    logic [15:0] dma_rdata;
    logic        dma_gnt;
    logic        dma_done;
    // SRAM wrapper side
    logic        mem_en;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_done, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_rdata, dma_gnt, dma_done,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_done, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_rdata, dma_gnt, dma_done,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single 2K x 16 data-memory port between the
// pipeline MEM stage (CPU) and a DMA/debug loader. Each access runs
// IDLE -> ACCESS (LAT cycles) -> DONE. Default arbitration is CPU priority
// with a starvation guard that forces DMA through after MAX_WAIT denials.
// Define ARB_ROUND_ROBIN_EN to alternate ownership on simultaneous requests
// instead (CPU first after reset).
module mem_port_arbiter #(
    parameter int LAT      = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,     // asynchronous, active low
    mem_port_arbiter_if.slave arb_if
);
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(LAT - 1);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;          // 0 = CPU, 1 = DMA
    logic [3:0]  cnt_q, cnt_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic [10:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] dma_rdata_q, dma_rdata_d;
    logic        cpu_done_q, cpu_done_d;
    logic        dma_done_q, dma_done_d;
    logic        dma_gnt_q, dma_gnt_d;
    logic        cpu_win, dma_win;

`ifdef ARB_ROUND_ROBIN_EN
    // set when DMA should win the next simultaneous request
    logic        dma_pri_q, dma_pri_d;

    // winner selection: alternate owners when both request
    always_comb begin
        dma_win = arb_if.dma_req & (~arb_if.cpu_req | dma_pri_q);
        cpu_win = arb_if.cpu_req & ~dma_win;
    end

    // priority flips to whoever did not win the latest grant
    always_comb begin
        dma_pri_d = dma_pri_q;
        if (state_q == ST_IDLE && (cpu_win || dma_win)) begin
            dma_pri_d = cpu_win;
        end
    end

    // priority register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dma_pri_q <= 1'b0;
        end else begin
            dma_pri_q <= dma_pri_d;
        end
    end
`else
    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);
    logic [7:0] wait_cnt_q, wait_cnt_d;

    // winner selection: CPU first unless DMA has waited MAX_WAIT grants
    always_comb begin
        dma_win = arb_if.dma_req & (~arb_if.cpu_req | (wait_cnt_q == WAIT_MAX));
        cpu_win = arb_if.cpu_req & ~dma_win;
    end

    // count CPU grants taken while DMA was waiting; saturate at the limit
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!arb_if.dma_req) begin
            wait_cnt_d = 8'd0;
        end else if (state_q == ST_IDLE) begin
            if (dma_win) begin
                wait_cnt_d = 8'd0;
            end else if (cpu_win && wait_cnt_q != WAIT_MAX) begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
        end
    end

    // starvation counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= 8'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    // FSM next state and registered outputs; all outputs hold unless changed
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        cpu_done_d  = 1'b0;
        dma_done_d  = 1'b0;
        dma_gnt_d   = dma_gnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_win || dma_win) begin
                    state_d   = ST_ACCESS;
                    owner_d   = dma_win;
                    cnt_d     = 4'd0;
                    mem_en_d  = 1'b1;
                    dma_gnt_d = dma_win;
                    if (dma_win) begin
                        mem_we_d    = arb_if.dma_we;
                        mem_addr_d  = arb_if.dma_addr;
                        mem_wdata_d = arb_if.dma_wdata;
                    end else begin
                        mem_we_d    = arb_if.cpu_we;
                        mem_addr_d  = arb_if.cpu_addr;
                        mem_wdata_d = arb_if.cpu_wdata;
                    end
                end
            end
            ST_ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_DONE;
                    cnt_d    = 4'd0;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    // read data is only valid on the final access cycle
                    if (!mem_we_q) begin
                        if (owner_q) begin
                            dma_rdata_d = arb_if.mem_rdata;
                        end else begin
                            cpu_rdata_d = arb_if.mem_rdata;
                        end
                    end
                    if (owner_q) begin
                        dma_done_d = 1'b1;
                    end else begin
                        cpu_done_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                dma_gnt_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state and output registers; reset abandons any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            cnt_q       <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 11'd0;
            mem_wdata_q <= 16'd0;
            cpu_rdata_q <= 16'd0;
            dma_rdata_q <= 16'd0;
            cpu_done_q  <= 1'b0;
            dma_done_q  <= 1'b0;
            dma_gnt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            cpu_done_q  <= cpu_done_d;
            dma_done_q  <= dma_done_d;
            dma_gnt_q   <= dma_gnt_d;
        end
    end

    assign arb_if.mem_en    = mem_en_q;
    assign arb_if.mem_we    = mem_we_q;
    assign arb_if.mem_addr  = mem_addr_q;
    assign arb_if.mem_wdata = mem_wdata_q;
    assign arb_if.cpu_rdata = cpu_rdata_q;
    assign arb_if.dma_rdata = dma_rdata_q;
    assign arb_if.cpu_done  = cpu_done_q;
    assign arb_if.dma_done  = dma_done_q;
    assign arb_if.dma_gnt   = dma_gnt_q;
    // hold the pipeline until the done cycle so it advances exactly once
    assign arb_if.cpu_stall = arb_if.cpu_req & ~cpu_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed test of mem_port_arbiter with LAT=2,
// MAX_WAIT=4 and a behavioural 2K x 16 SRAM. Expected owner order in the
// contention test follows ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_port_arbiter;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [15:0] sram [0:2047];

    mem_port_arbiter_if arb ();

    mem_port_arbiter #(.LAT(2), .MAX_WAIT(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .arb_if (arb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural SRAM: synchronous write, data visible while addressed
    always @(posedge clk) begin
        if (arb.mem_en && arb.mem_we) sram[arb.mem_addr] <= arb.mem_wdata;
    end
    assign arb.mem_rdata = sram[arb.mem_addr];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #2;
    endtask

    // one CPU transaction; drives in the current IDLE cycle, ends one cycle after done
    task automatic cpu_xfer(input string tag, input logic we, input logic [10:0] addr,
                            input logic [15:0] wdata, input logic [15:0] exp_rd);
        int lat;
        bit seen;
        arb.cpu_req = 1'b1; arb.cpu_we = we; arb.cpu_addr = addr; arb.cpu_wdata = wdata;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 12) begin
            next_cyc();
            lat++;
            if (arb.cpu_done) seen = 1'b1;
        end
        check_val({tag, "_lat"}, lat, 3);
        if (!we) check_val({tag, "_rdata"}, arb.cpu_rdata, exp_rd);
        $display("xfer %s: cpu we=%0d addr=%h wdata=%h rdata=%h lat=%0d",
                 tag, we, addr, wdata, arb.cpu_rdata, lat);
        arb.cpu_req = 1'b0;
        next_cyc();
    endtask

    // one DMA write transaction
    task automatic dma_write(input string tag, input logic [10:0] addr, input logic [15:0] wdata);
        int lat;
        bit seen;
        arb.dma_req = 1'b1; arb.dma_we = 1'b1; arb.dma_addr = addr; arb.dma_wdata = wdata;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 12) begin
            next_cyc();
            lat++;
            if (arb.dma_done) seen = 1'b1;
        end
        check_val({tag, "_lat"}, lat, 3);
        check_val({tag, "_gnt"}, arb.dma_gnt, 1);
        $display("xfer %s: dma write addr=%h wdata=%h lat=%0d", tag, addr, wdata, lat);
        arb.dma_req = 1'b0;
        next_cyc();
        check_val({tag, "_gnt_off"}, arb.dma_gnt, 0);
        check_val({tag, "_sram"}, sram[addr], wdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit [9:0] exp_own;
        int n;
        int last;
        logic got_owner;

`ifdef ARB_ROUND_ROBIN_EN
        exp_own = 10'b01_0101_0101;
`else
        exp_own = 10'b10_0001_0000;
`endif
        total = 0; bad = 0;
        for (int i = 0; i < 2048; i++) sram[i] = 16'h0000;
        sram[11'h010] = 16'h5A5A;
        rst = 1'b0;
        arb.cpu_req = 1'b0; arb.cpu_we = 1'b0; arb.cpu_addr = '0; arb.cpu_wdata = '0;
        arb.dma_req = 1'b0; arb.dma_we = 1'b0; arb.dma_addr = '0; arb.dma_wdata = '0;

        // reset state
        repeat (3) next_cyc();
        check_val("rst_mem_en", arb.mem_en, 0);
        check_val("rst_cpu_done", arb.cpu_done, 0);
        check_val("rst_dma_gnt", arb.dma_gnt, 0);
        check_val("rst_cpu_rdata", arb.cpu_rdata, 0);
        check_val("rst_stall", arb.cpu_stall, 0);
        rst = 1'b1;
        next_cyc();

        // T1: CPU write 0x0123 to 0x005 with cycle-by-cycle checks
        arb.cpu_req = 1'b1; arb.cpu_we = 1'b1; arb.cpu_addr = 11'h005; arb.cpu_wdata = 16'h0123;
        #1;
        check_val("t1_c0_stall", arb.cpu_stall, 1);
        check_val("t1_c0_mem_en", arb.mem_en, 0);
        next_cyc();
        check_val("t1_c1_mem_en", arb.mem_en, 1);
        check_val("t1_c1_mem_we", arb.mem_we, 1);
        check_val("t1_c1_addr", arb.mem_addr, 11'h005);
        check_val("t1_c1_wdata", arb.mem_wdata, 16'h0123);
        check_val("t1_c1_stall", arb.cpu_stall, 1);
        // changes after grant must not reach the SRAM
        arb.cpu_addr = 11'h7FF; arb.cpu_wdata = 16'hFFFF;
        next_cyc();
        check_val("t1_c2_mem_en", arb.mem_en, 1);
        check_val("t1_c2_addr", arb.mem_addr, 11'h005);
        check_val("t1_c2_stall", arb.cpu_stall, 1);
        check_val("t1_c2_done", arb.cpu_done, 0);
        next_cyc();
        check_val("t1_c3_done", arb.cpu_done, 1);
        check_val("t1_c3_mem_en", arb.mem_en, 0);
        check_val("t1_c3_stall", arb.cpu_stall, 0);
        $display("xfer t1: cpu write addr=005 wdata=0123");
        arb.cpu_req = 1'b0;
        next_cyc();
        check_val("t1_c4_done", arb.cpu_done, 0);

        // T2: read back
        cpu_xfer("t2", 1'b0, 11'h005, 16'h0000, 16'h0123);
        check_val("t2_sram_7ff", sram[11'h7FF], 16'h0000);

        // T2b: lone DMA write (also leaves DMA as last owner)
        dma_write("t2b", 11'h040, 16'h1111);

        // T3: simultaneous CPU read 0x010 and DMA write 0xBEEF to 0x020
        arb.cpu_req = 1'b1; arb.cpu_we = 1'b0; arb.cpu_addr = 11'h010;
        arb.dma_req = 1'b1; arb.dma_we = 1'b1; arb.dma_addr = 11'h020; arb.dma_wdata = 16'hBEEF;
        next_cyc();
        check_val("t3_c1_gnt", arb.dma_gnt, 0);
        check_val("t3_c1_addr", arb.mem_addr, 11'h010);
        next_cyc();
        next_cyc();
        check_val("t3_c3_cpu_done", arb.cpu_done, 1);
        check_val("t3_c3_dma_done", arb.dma_done, 0);
        check_val("t3_c3_rdata", arb.cpu_rdata, 16'h5A5A);
        $display("xfer t3a: cpu read addr=010 rdata=%h", arb.cpu_rdata);
        arb.cpu_req = 1'b0;
        next_cyc();
        check_val("t3_c4_mem_en", arb.mem_en, 0);
        next_cyc();
        check_val("t3_c5_gnt", arb.dma_gnt, 1);
        check_val("t3_c5_addr", arb.mem_addr, 11'h020);
        check_val("t3_c5_we", arb.mem_we, 1);
        check_val("t3_c5_wdata", arb.mem_wdata, 16'hBEEF);
        next_cyc();
        next_cyc();
        check_val("t3_c7_dma_done", arb.dma_done, 1);
        check_val("t3_c7_gnt", arb.dma_gnt, 1);
        $display("xfer t3b: dma write addr=020 wdata=BEEF");
        arb.dma_req = 1'b0;
        next_cyc();
        check_val("t3_c8_gnt", arb.dma_gnt, 0);
        cpu_xfer("t3c", 1'b0, 11'h020, 16'h0000, 16'hBEEF);

        // T4: both requesters held continuously
        arb.cpu_req = 1'b1; arb.cpu_we = 1'b0; arb.cpu_addr = 11'h005;
        arb.dma_req = 1'b1; arb.dma_we = 1'b0; arb.dma_addr = 11'h020;
        n = 0; last = 0;
        for (int c = 0; c < 60 && n < 10; c++) begin
            next_cyc();
            if (arb.cpu_done || arb.dma_done) begin
                got_owner = arb.dma_done;
                check_val($sformatf("t4_owner%0d", n), got_owner, exp_own[n]);
                if (arb.dma_done) begin
                    check_val($sformatf("t4_dma_rd%0d", n), arb.dma_rdata, 16'hBEEF);
                    check_val($sformatf("t4_cpu_req%0d", n), arb.cpu_req, 1);
                end else begin
                    check_val($sformatf("t4_cpu_rd%0d", n), arb.cpu_rdata, 16'h0123);
                end
                check_val($sformatf("t4_gap%0d", n), c + 1 - last, (n == 0) ? 3 : 4);
                $display("xfer t4.%0d: owner=%s cycle=%0d", n, got_owner ? "dma" : "cpu", c + 1);
                last = c + 1;
                n++;
            end
        end
        check_val("t4_count", n, 10);
        arb.cpu_req = 1'b0; arb.dma_req = 1'b0;
        next_cyc();

        // T5: reset in the second ACCESS cycle of a CPU write
        arb.cpu_req = 1'b1; arb.cpu_we = 1'b1; arb.cpu_addr = 11'h030; arb.cpu_wdata = 16'h0777;
        next_cyc();
        next_cyc();
        check_val("t5_pre_mem_en", arb.mem_en, 1);
        rst = 1'b0;
        #1;
        check_val("t5_rst_mem_en", arb.mem_en, 0);
        check_val("t5_rst_stall", arb.cpu_stall, 1);
        check_val("t5_rst_rdata", arb.cpu_rdata, 0);
        check_val("t5_rst_addr", arb.mem_addr, 0);
        check_val("t5_rst_wdata", arb.mem_wdata, 0);
        check_val("t5_rst_dma_rdata", arb.dma_rdata, 0);
        next_cyc();
        check_val("t5_hold_done", arb.cpu_done, 0);
        arb.cpu_req = 1'b0;
        next_cyc();
        rst = 1'b1;
        next_cyc();
        check_val("t5_post_done", arb.cpu_done, 0);
        check_val("t5_post_mem_en", arb.mem_en, 0);
        check_val("t5_post_gnt", arb.dma_gnt, 0);
        $display("xfer t5: cpu write addr=030 abandoned by reset");
        cpu_xfer("t5r", 1'b0, 11'h005, 16'h0000, 16'h0123);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
